// File: rtl/nn_layer_pkg.sv
// nn_layer_pkg: shared types and constants for the layer sequencer.
// Covers status/command encodings, state type and Q8.8 scaling.
package nn_layer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_DONE = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;

  localparam logic [1:0] CMD_GO = 2'b01;
  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;

  localparam int Q_SHIFT = 8;
  localparam int SAT_MAX = 32767;

endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: registered Q8.8 multiply, wide accumulate, bias add,
// rescale, ReLU and saturation for one neuron at a time.
module nn_mac_unit
  import nn_layer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bias_en,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    xe;
  logic signed [PW-1:0]    we;
  logic signed [PW-1:0]    prod;
  logic                    prod_v;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pe;
  logic signed [ACC_W-1:0] be;
  logic signed [ACC_W-1:0] sh;
  logic signed [ACC_W-1:0] lim;

  assign xe  = {{DATA_W{x[DATA_W-1]}}, x};
  assign we  = {{DATA_W{w[DATA_W-1]}}, w};
  assign pe  = prod_v ? {{(ACC_W-PW){prod[PW-1]}}, prod} : '0;
  // Bias is Q8.8; shift it up to the Q16.16 product scale.
  assign be  = bias_en
             ? {{(ACC_W-DATA_W-Q_SHIFT){b[DATA_W-1]}}, b, {Q_SHIFT{1'b0}}}
             : '0;
  assign sh  = acc >>> Q_SHIFT;
  assign lim = ACC_W'(SAT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else if (clr) begin
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      prod_v <= en;
      if (en) prod <= xe * we;
      acc <= acc + pe + be;
    end
  end

  always_comb begin
    y = sh[DATA_W-1:0];
    if (sh[ACC_W-1]) y = '0;
    else if (sh > lim) y = {1'b0, {(DATA_W-1){1'b1}}};
  end

endmodule

// File: rtl/nn_layer_seq.sv
// nn_layer_seq: PIO-commanded sequencer running one fully-connected
// ReLU layer over external x/w/b memories into y memory.
module nn_layer_seq
  import nn_layer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int MAX_IN  = 64,
  parameter int MAX_OUT = 16,
  parameter int XA_W    = 6,
  parameter int WA_W    = 10,
  parameter int YA_W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        to_hw_sig,
  input  logic [XA_W:0]     n_in,
  input  logic [YA_W:0]     n_out,
  output logic [1:0]        to_sw_sig,
  output logic              busy,
  output logic [XA_W-1:0]   x_addr,
  input  logic [DATA_W-1:0] x_rddata,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rddata,
  output logic [YA_W-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_rddata,
  output logic [YA_W-1:0]   y_addr,
  output logic [DATA_W-1:0] y_wrdata,
  output logic              y_we
);

  state_t          st;
  state_t          nxt;
  logic [1:0]      cmd_q;
  logic [XA_W:0]   n_in_q;
  logic [XA_W:0]   i_cnt;
  logic [YA_W:0]   n_out_q;
  logic [YA_W-1:0] j;
  logic [WA_W-1:0] w_cnt;
  logic            drn;
  logic            issue_q;
  logic            start;
  logic            bad;
  logic            last_i;
  logic            last_j;
  logic            clr;

  assign start  = (st == S_IDLE) && (cmd_q == CMD_GO);
  assign bad    = (n_in_q == '0) || (n_out_q == '0)
               || (n_in_q > (XA_W+1)'(MAX_IN))
               || (n_out_q > (YA_W+1)'(MAX_OUT));
  assign last_i = i_cnt == n_in_q - 1'b1;
  assign last_j = {1'b0, j} == n_out_q - 1'b1;

  always_comb begin
    nxt = st;
    if (cmd_q[CMD_ABORT]) begin
      nxt = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE:  if (start) nxt = S_CHECK;
        S_CHECK: nxt = bad ? S_ERR : S_MAC;
        S_MAC:   if (last_i) nxt = S_DRAIN;
        S_DRAIN: if (drn) nxt = S_BIAS;
        S_BIAS:  nxt = S_WRITE;
        S_WRITE: nxt = last_j ? S_DONE : S_MAC;
        S_DONE,
        S_ERR:   if (!cmd_q[CMD_START]) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= S_IDLE;
    else          st <= nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q   <= '0;
      issue_q <= 1'b0;
      n_in_q  <= '0;
      n_out_q <= '0;
      i_cnt   <= '0;
      j       <= '0;
      w_cnt   <= '0;
      drn     <= 1'b0;
    end else begin
      cmd_q   <= to_hw_sig;
      issue_q <= st == S_MAC;
      if (start) begin
        n_in_q  <= n_in;
        n_out_q <= n_out;
      end
      case (st)
        S_CHECK: begin
          i_cnt <= '0;
          j     <= '0;
          w_cnt <= '0;
          drn   <= 1'b0;
        end
        // w_cnt runs across rows, giving j*n_in+i without a multiplier.
        S_MAC: begin
          w_cnt <= w_cnt + 1'b1;
          i_cnt <= last_i ? '0 : i_cnt + 1'b1;
        end
        S_DRAIN: drn <= ~drn;
        S_WRITE: if (!last_j) j <= j + 1'b1;
        default: ;
      endcase
    end
  end

  assign clr = (st == S_IDLE) || (st == S_CHECK) || (st == S_WRITE)
            || (st == S_DONE) || (st == S_ERR);

  nn_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (issue_q),
    .bias_en (st == S_BIAS),
    .x       (x_rddata),
    .w       (w_rddata),
    .b       (b_rddata),
    .y       (y_wrdata)
  );

  assign x_addr    = i_cnt[XA_W-1:0];
  assign w_addr    = w_cnt;
  assign b_addr    = j;
  assign y_addr    = j;
  assign y_we      = st == S_WRITE;
  assign busy      = (st == S_CHECK) || (st == S_MAC) || (st == S_DRAIN)
                  || (st == S_BIAS) || (st == S_WRITE);
  assign to_sw_sig = (st == S_DONE) ? ST_DONE
                   : (st == S_ERR)  ? ST_ERR : ST_NONE;

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq: table-driven and randomized checks of nn_layer_seq
// against a plain-arithmetic layer model and memory models.
module tb_nn_layer_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  to_hw_sig;
  logic [6:0]  n_in;
  logic [4:0]  n_out;
  logic [1:0]  to_sw_sig;
  logic        busy;
  logic [5:0]  x_addr;
  logic [15:0] x_rddata;
  logic [9:0]  w_addr;
  logic [15:0] w_rddata;
  logic [3:0]  b_addr;
  logic [15:0] b_rddata;
  logic [3:0]  y_addr;
  logic [15:0] y_wrdata;
  logic        y_we;

  logic [15:0] x_mem [64];
  logic [15:0] w_mem [1024];
  logic [15:0] b_mem [16];
  logic [15:0] ycap [16];
  int          ycap_run [16];
  int          seen_run [1024];
  int          wr_cnt = 0;
  int          cur_run = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    int nin;
    int nout;
    int mode;
    bit err;
    int hold;
    int exp_y;
  } vec_t;

  nn_layer_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .to_hw_sig (to_hw_sig),
    .n_in      (n_in),
    .n_out     (n_out),
    .to_sw_sig (to_sw_sig),
    .busy      (busy),
    .x_addr    (x_addr),
    .x_rddata  (x_rddata),
    .w_addr    (w_addr),
    .w_rddata  (w_rddata),
    .b_addr    (b_addr),
    .b_rddata  (b_rddata),
    .y_addr    (y_addr),
    .y_wrdata  (y_wrdata),
    .y_we      (y_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_rddata <= x_mem[x_addr];
    w_rddata <= w_mem[w_addr];
    b_rddata <= b_mem[b_addr];
  end

  always @(negedge clk) begin
    if (y_we) begin
      ycap[y_addr]     <= y_wrdata;
      ycap_run[y_addr] <= cur_run;
      wr_cnt           <= wr_cnt + 1;
    end
    if (busy) seen_run[w_addr] <= cur_run;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ref_y(int j, int nin);
    longint acc;
    longint xv;
    longint wv;
    acc = 0;
    for (int i = 0; i < nin; i++) begin
      xv = longint'($signed(x_mem[i]));
      wv = longint'($signed(w_mem[j*nin+i]));
      acc += xv * wv;
    end
    acc += longint'($signed(b_mem[j])) * 256;
    acc = acc >>> 8;
    if (acc < 0) return 0;
    if (acc > 32767) return 32767;
    return acc;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 64; i++) begin
      x_mem[i] = (mode == 3) ? 16'h7FFF
               : (mode == 4) ? 16'($urandom_range(0, 2047) - 1024)
               : 16'($urandom);
    end
    for (int k = 0; k < 1024; k++) begin
      w_mem[k] = (mode == 3) ? 16'h7FFF
               : (mode == 4) ? 16'($urandom_range(0, 2047) - 1024)
               : 16'($urandom);
    end
    for (int k = 0; k < 16; k++) begin
      b_mem[k] = (mode == 3) ? 16'h0000 : 16'($urandom);
    end
    if (mode == 1 || mode == 2) begin
      x_mem[0] = 16'h0100;
      x_mem[1] = 16'h0200;
      w_mem[0] = 16'h0080;
      w_mem[1] = 16'h0040;
      b_mem[0] = (mode == 1) ? 16'h0010 : 16'hFE00;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int w0;
    int bad;
    int nseen;
    longint got;
    cur_run++;
    fill(v.mode);
    w0 = wr_cnt;
    @(posedge clk); #1;
    n_in      = 7'(v.nin);
    n_out     = 5'(v.nout);
    to_hw_sig = 2'b01;
    cyc = 0;
    while (to_sw_sig == 2'b00 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, v.err ? 3 : 3 + v.nout * (v.nin + 4));
    check("status", to_sw_sig, v.err ? 2 : 1);
    check("busy_end", busy, 0);
    bad = 0;
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk); #1;
      if (to_sw_sig !== (v.err ? 2'b10 : 2'b01) || busy !== 1'b0) bad++;
    end
    if (v.hold > 0) check("hold_status", bad, 0);
    check("writes", wr_cnt - w0, v.err ? 0 : v.nout);
    if (!v.err) begin
      for (int j = 0; j < v.nout; j++) begin
        got = (ycap_run[j] == cur_run) ? longint'(ycap[j]) : -1;
        check($sformatf("y[%0d]", j), got, ref_y(j, v.nin));
        if (v.exp_y >= 0) check($sformatf("y_const[%0d]", j), got, v.exp_y);
      end
      nseen = 0;
      for (int k = 0; k < v.nin * v.nout; k++) begin
        if (seen_run[k] == cur_run) nseen++;
      end
      check("w_walk", nseen, v.nin * v.nout);
    end
    @(posedge clk); #1;
    to_hw_sig = 2'b00;
    cyc = 0;
    while (to_sw_sig != 2'b00 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("clear_lat", cyc, 2);
  endtask

  task automatic run_abort();
    int cyc;
    int w0;
    longint got;
    cur_run++;
    fill(4);
    w0 = wr_cnt;
    @(posedge clk); #1;
    n_in      = 7'd64;
    n_out     = 5'd16;
    to_hw_sig = 2'b01;
    cyc = 0;
    while (wr_cnt - w0 < 5 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach5", wr_cnt - w0, 5);
    to_hw_sig = 2'b11;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_busy", busy, 0);
    check("abort_status", to_sw_sig, 0);
    repeat (150) begin
      @(posedge clk); #1;
    end
    check("abort_writes", wr_cnt - w0, 5);
    check("abort_busy_late", busy, 0);
    for (int j = 0; j < 5; j++) begin
      got = (ycap_run[j] == cur_run) ? longint'(ycap[j]) : -1;
      check($sformatf("abort_y[%0d]", j), got, ref_y(j, 64));
    end
    to_hw_sig = 2'b00;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t tbl [9];
    vec_t rv;
    tbl[0] = '{2, 1, 1, 1'b0, 0, 'h0110};
    tbl[1] = '{2, 1, 2, 1'b0, 0, 0};
    tbl[2] = '{4, 2, 3, 1'b0, 0, 'h7FFF};
    tbl[3] = '{0, 3, 0, 1'b1, 0, -1};
    tbl[4] = '{65, 1, 0, 1'b1, 0, -1};
    tbl[5] = '{5, 17, 0, 1'b1, 0, -1};
    tbl[6] = '{64, 16, 4, 1'b0, 0, -1};
    tbl[7] = '{2, 1, 1, 1'b0, 20, 'h0110};
    tbl[8] = '{1, 1, 4, 1'b0, 0, -1};

    for (int k = 0; k < 16; k++) ycap_run[k] = 0;
    for (int k = 0; k < 1024; k++) seen_run[k] = 0;
    reset_n   = 1'b0;
    to_hw_sig = 2'b00;
    n_in      = '0;
    n_out     = '0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_to_sw", to_sw_sig, 0);
    check("rst_busy", busy, 0);
    check("rst_y_we", y_we, 0);
    check("rst_x_addr", x_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_b_addr", b_addr, 0);
    check("rst_y_addr", y_addr, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 9; t++) run_vec(tbl[t]);

    for (int r = 0; r < 6; r++) begin
      rv = '{int'($urandom_range(1, 24)), int'($urandom_range(1, 6)),
             (r % 2 == 0) ? 0 : 4, 1'b0, 0, -1};
      run_vec(rv);
    end

    run_abort();
    rv = '{3, 4, 4, 1'b0, 0, -1};
    run_vec(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
